// File: rtl/mdu_pkg.sv
// ============================================================================
// Module      : mdu_pkg
// Description : Op codes, default cycle counts and op-class helpers for the
//               HI/LO multiply/divide unit. Optional macro: MDU_MADD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_t;

  function automatic logic is_mul_op(input logic [3:0] op);
    logic r;
    r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
    r = r || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_compute.sv
// ============================================================================
// Module      : mdu_compute
// Description : Combinational 64-bit {HI,LO} result calculator. Accumulate
//               ops exist only when MDU_MADD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_compute
  import mdu_pkg::*;
(
`ifdef MDU_MADD_EN
  input  logic [31:0] hi,
  input  logic [31:0] lo,
`endif
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        wr_en
);

  logic signed [63:0] sa, sb, prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a, abs_b, div_s, div_u, q_mag, r_mag, q_s, r_s, q_u, r_u;

  always_comb begin
    sa     = {{32{a[31]}}, a};
    sb     = {{32{b[31]}}, b};
    prod_s = sa * sb;
    prod_u = {32'd0, a} * {32'd0, b};

    // Signed division on magnitudes so 0x80000000 / -1 wraps cleanly.
    abs_a = a[31] ? (~a + 32'd1) : a;
    abs_b = b[31] ? (~b + 32'd1) : b;
    div_s = (b == 32'd0) ? 32'd1 : abs_b;
    div_u = (b == 32'd0) ? 32'd1 : b;
    q_mag = abs_a / div_s;
    r_mag = abs_a % div_s;
    q_s   = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
    r_s   = a[31] ? (~r_mag + 32'd1) : r_mag;
    q_u   = a / div_u;
    r_u   = a % div_u;

    result = '0;
    wr_en  = 1'b1;
    case (op)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV:   begin result = {r_s, q_s}; wr_en = (b != 32'd0); end
      OP_DIVU:  begin result = {r_u, q_u}; wr_en = (b != 32'd0); end
`ifdef MDU_MADD_EN
      OP_MADD:  result = {hi, lo} + $unsigned(prod_s);
      OP_MADDU: result = {hi, lo} + prod_u;
      OP_MSUB:  result = {hi, lo} - $unsigned(prod_s);
      OP_MSUBU: result = {hi, lo} - prod_u;
`endif
      default:  wr_en = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module      : mult_div_unit
// Description : Multi-cycle HI/LO multiply/divide unit with busy handshake.
//               MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (codes 6-9).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [3:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  mdu_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [63:0] result;
  logic        wr_en;

  // HI/LO cannot change during RUN, so the live values equal the start-edge ones.
  mdu_compute u_compute (
`ifdef MDU_MADD_EN
    .hi     (hi_q),
    .lo     (lo_q),
`endif
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (result),
    .wr_en  (wr_en)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if (is_mul_op(Op) || is_div_op(Op)) begin
            state_d = ST_RUN;
            op_d    = Op;
            a_d     = A;
            b_d     = B;
            cnt_d   = is_div_op(Op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          end else if (Op == OP_MTHI) begin
            hi_d = A;
          end else if (Op == OP_MTLO) begin
            lo_d = A;
          end
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (wr_en) {hi_d, lo_d} = result;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy = (state_q == ST_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit (vector table, corner
//               sequences, randomized ops vs. arithmetic model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [3:0]  Op    = 4'd0;
  logic [31:0] A     = 32'd0;
  logic [31:0] B     = 32'd0;
  logic        Busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Start (Start),
    .Op    (Op),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural HI/LO pair.
  task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          inout logic [31:0] hi, inout logic [31:0] lo, output int cyc);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     acc;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = a;
    ub  = b;
    acc = {hi, lo};
    cyc = 0;
    case (op)
      4'd0: begin acc = sa * sb; cyc = MC; end
      4'd1: begin acc = ua * ub; cyc = MC; end
      4'd2: begin
        cyc = DC;
        if (b != 0) begin q = sa / sb; r = sa % sb; acc = {r[31:0], q[31:0]}; end
      end
      4'd3: begin
        cyc = DC;
        if (b != 0) begin q = longint'(ua / ub); r = longint'(ua % ub); acc = {r[31:0], q[31:0]}; end
      end
      4'd4: acc[63:32] = a;
      4'd5: acc[31:0]  = a;
`ifdef MDU_MADD_EN
      4'd6: begin acc = acc + 64'(sa * sb); cyc = MC; end
      4'd7: begin acc = acc + 64'(ua * ub); cyc = MC; end
      4'd8: begin acc = acc - 64'(sa * sb); cyc = MC; end
      4'd9: begin acc = acc - 64'(ua * ub); cyc = MC; end
`endif
      default: ;
    endcase
    hi = acc[63:32];
    lo = acc[31:0];
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cnt, output bit stable);
    logic [31:0] h0, l0;
    @(negedge Clock);
    Start = 1'b1; Op = op; A = a; B = b;
    h0 = HI; l0 = LO;
    @(posedge Clock);
    #1 Start = 1'b0;
    cnt = 0;
    stable = 1'b1;
    @(negedge Clock);
    while (Busy && cnt < 64) begin
      cnt++;
      if (HI !== h0 || LO !== l0) stable = 1'b0;
      @(negedge Clock);
    end
  endtask

  task automatic add_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo, input int cyc);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.cyc = cyc;
    tbl.push_back(v);
  endtask

  initial begin
    int          cnt, ecyc;
    bit          stable;
    logic [31:0] eh, el;
    logic [3:0]  op;
    logic [31:0] ra, rb;

    add_vec(4'd0,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MC);
    add_vec(4'd1,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC);
    add_vec(4'd2,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC);
    add_vec(4'd3,  32'd1234,     32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, DC);
    add_vec(4'd2,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC);
    add_vec(4'd4,  32'h12345678, 32'd0,        32'h12345678, 32'h80000000, 0);
    add_vec(4'd5,  32'hFFFFFFFF, 32'd0,        32'h12345678, 32'hFFFFFFFF, 0);
    add_vec(4'd15, 32'hCAFEF00D, 32'd7,        32'h12345678, 32'hFFFFFFFF, 0);
    add_vec(4'd4,  32'h00000000, 32'd0,        32'h00000000, 32'hFFFFFFFF, 0);
`ifdef MDU_MADD_EN
    add_vec(4'd7,  32'd1,        32'd1,        32'h00000001, 32'h00000000, MC);
`else
    add_vec(4'd7,  32'd1,        32'd1,        32'h00000000, 32'hFFFFFFFF, 0);
`endif
    add_vec(4'd3,  32'd7,        32'd2,        32'h00000001, 32'h00000003, DC);

    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    @(negedge Clock);
    check("reset_busy", {63'd0, Busy}, 64'd0);
    check("reset_hi", {32'd0, HI}, 64'd0);
    check("reset_lo", {32'd0, LO}, 64'd0);

    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, cnt, stable);
      check($sformatf("vec%0d_busy_cycles", i), 64'(cnt), 64'(tbl[i].cyc));
      check($sformatf("vec%0d_stable", i), {63'd0, stable}, 64'd1);
      check($sformatf("vec%0d_hi", i), {32'd0, HI}, {32'd0, tbl[i].hi});
      check($sformatf("vec%0d_lo", i), {32'd0, LO}, {32'd0, tbl[i].lo});
    end

    // Start during RUN must be ignored.
    @(negedge Clock);
    Start = 1'b1; Op = 4'd1; A = 32'd3; B = 32'd4;
    @(posedge Clock);
    #1 Start = 1'b0;
    cnt = 0;
    @(negedge Clock);
    while (Busy && cnt < 64) begin
      cnt++;
      if (cnt == 2) begin Start = 1'b1; Op = 4'd4; A = 32'hDEADBEEF; end
      else Start = 1'b0;
      @(negedge Clock);
    end
    Start = 1'b0;
    check("busy_start_cycles", 64'(cnt), 64'(MC));
    check("busy_start_hi", {32'd0, HI}, 64'd0);
    check("busy_start_lo", {32'd0, LO}, 64'd12);

    // Reset on the third busy cycle of a DIV aborts it.
    @(negedge Clock);
    Start = 1'b1; Op = 4'd2; A = 32'd100; B = 32'd7;
    @(posedge Clock);
    #1 Start = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock);
    #1 Reset = 1'b0;
    @(negedge Clock);
    check("abort_busy", {63'd0, Busy}, 64'd0);
    check("abort_hi", {32'd0, HI}, 64'd0);
    check("abort_lo", {32'd0, LO}, 64'd0);
    repeat (15) @(negedge Clock);
    check("abort_late_busy", {63'd0, Busy}, 64'd0);
    check("abort_late_hilo", {HI, LO}, 64'd0);

    // Reset wins over a simultaneous MTHI.
    @(negedge Clock);
    Reset = 1'b1; Start = 1'b1; Op = 4'd4; A = 32'h5A5A5A5A;
    @(posedge Clock);
    #1 begin Reset = 1'b0; Start = 1'b0; end
    @(negedge Clock);
    check("reset_prio_hi", {32'd0, HI}, 64'd0);
    check("reset_prio_busy", {63'd0, Busy}, 64'd0);

    m_hi = 32'd0;
    m_lo = 32'd0;
    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom_range(0, 11));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 9));
        2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        default: ;
      endcase
      eh = m_hi;
      el = m_lo;
      model_op(op, ra, rb, eh, el, ecyc);
      run_op(op, ra, rb, cnt, stable);
      check($sformatf("rnd%0d_op%0d_cycles", k, op), 64'(cnt), 64'(ecyc));
      check($sformatf("rnd%0d_op%0d_stable", k, op), {63'd0, stable}, 64'd1);
      check($sformatf("rnd%0d_op%0d_a%h_b%h_hilo", k, op, ra, rb), {HI, LO}, {eh, el});
      m_hi = eh;
      m_lo = el;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
